// File: rtl/vga_pkg.sv
// Shared VGA definitions: active resolution, pattern mode encodings, bar colours
// and the per-axis bounce step used by the box mover.
package vga_pkg;

  // Active area shared with the timing controller's H/V data times.
  localparam int VGA_H_DATA = 800;
  localparam int VGA_V_DATA = 480;

  typedef enum logic [1:0] {
    MODE_BARS    = 2'd0,
    MODE_CHECKER = 2'd1,
    MODE_GRID    = 2'd2,
    MODE_BOX     = 2'd3
  } mode_e;

  localparam logic [23:0] RGB_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] RGB_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] RGB_CYAN    = 24'h00FFFF;
  localparam logic [23:0] RGB_GREEN   = 24'h00FF00;
  localparam logic [23:0] RGB_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] RGB_RED     = 24'hFF0000;
  localparam logic [23:0] RGB_BLUE    = 24'h0000FF;
  localparam logic [23:0] RGB_BLACK   = 24'h000000;

  // One bouncing axis: position plus direction (neg=1 means moving towards 0).
  typedef struct packed {
    logic [10:0] pos;
    logic        neg;
  } axis_t;

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return RGB_WHITE;
      3'd1:    return RGB_YELLOW;
      3'd2:    return RGB_CYAN;
      3'd3:    return RGB_GREEN;
      3'd4:    return RGB_MAGENTA;
      3'd5:    return RGB_RED;
      3'd6:    return RGB_BLUE;
      default: return RGB_BLACK;
    endcase
  endfunction

  // Sums are formed at 12 bits so pos+size+step cannot wrap.
  function automatic axis_t axis_step(input axis_t a, input int active,
                                      input int size, input int step);
    axis_t       r;
    logic [11:0] p12;
    r   = a;
    p12 = {1'b0, a.pos};
    if (!a.neg) begin
      if (p12 + 12'(size) + 12'(step) > 12'(active)) begin
        r.neg = 1'b1;
        r.pos = a.pos - 11'(step);
      end else begin
        r.pos = a.pos + 11'(step);
      end
    end else begin
      if (p12 < 12'(step)) begin
        r.neg = 1'b0;
        r.pos = a.pos + 11'(step);
      end else begin
        r.pos = a.pos - 11'(step);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/vga_box_mover.sv
// Bouncing-box position: both axes advance once per Frame_Start, reversing
// before any edge of the box would leave the active area.
module vga_box_mover
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_DATA,
  parameter int V_ACTIVE = VGA_V_DATA,
  parameter int BOX_SIZE = 64,
  parameter int BOX_STEP = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Frame_Start,
  output logic [10:0] Box_X,
  output logic [10:0] Box_Y
);

  axis_t ax, ay;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ax <= '0;
      ay <= '0;
    end else if (Frame_Start) begin
      ax <= axis_step(ax, H_ACTIVE, BOX_SIZE, BOX_STEP);
      ay <= axis_step(ay, V_ACTIVE, BOX_SIZE, BOX_STEP);
    end
  end

  assign Box_X = ax.pos;
  assign Box_Y = ay.pos;

endmodule

// File: rtl/vga_pattern_gen.sv
// Test-pattern pixel source: tracks the raster from Data_Req pulses, aligns to
// VGA_VS and decodes bars / checker / grid / box colours from registered state.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE    = VGA_H_DATA,
  parameter int V_ACTIVE    = VGA_V_DATA,
  parameter int CHECK_SHIFT = 5,
  parameter int BOX_SIZE    = 64,
  parameter int BOX_STEP    = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [1:0]  Mode,
  input  logic        Data_Req,
  input  logic        VGA_VS,
  output logic [23:0] DATA,
  output logic [10:0] Pix_X,
  output logic [10:0] Pix_Y,
  output logic        Frame_Start,
  output logic        Overrun
);

  localparam int          BAR_W     = H_ACTIVE / 8;
  localparam logic [10:0] X_LAST    = 11'(H_ACTIVE - 1);
  localparam logic [10:0] Y_LAST    = 11'(V_ACTIVE - 1);
  localparam logic [10:0] BAR_LAST  = 11'(BAR_W - 1);
  localparam logic [10:0] CELL_MASK = 11'((1 << CHECK_SHIFT) - 1);
  localparam logic [11:0] Y_END     = 12'(V_ACTIVE);
  localparam logic [11:0] BOX_LEN   = 12'(BOX_SIZE);

  logic [10:0] x, y;
  logic [10:0] bar_cnt;
  logic [2:0]  bar_idx;
  mode_e       mode_r;
  logic        vs_d;
  logic        overrun;
  logic [10:0] box_x, box_y;
  logic        y_end;
  logic        in_box;
  logic        grid_on;
  logic [23:0] data_c;

  assign Frame_Start = vs_d & ~VGA_VS;
  assign y_end       = {1'b0, y} >= Y_END;

  vga_box_mover #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .BOX_SIZE (BOX_SIZE),
    .BOX_STEP (BOX_STEP)
  ) u_box (
    .Clk         (Clk),
    .Reset       (Reset),
    .Frame_Start (Frame_Start),
    .Box_X       (box_x),
    .Box_Y       (box_y)
  );

  // NOTE: reset is synchronous and all state uses non-blocking assignments, so
  // every register in this block samples the values from before the edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      x       <= '0;
      y       <= '0;
      bar_cnt <= '0;
      bar_idx <= '0;
      mode_r  <= MODE_BARS;
      vs_d    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      vs_d <= VGA_VS;
      if (Frame_Start) begin
        // A request coincident with frame start is dropped deliberately.
        x       <= '0;
        y       <= '0;
        bar_cnt <= '0;
        bar_idx <= '0;
        mode_r  <= mode_e'(Mode);
        overrun <= 1'b0;
      end else if (Data_Req) begin
        if (y_end) begin
          overrun <= 1'b1;
        end else if (x == X_LAST) begin
          x       <= '0;
          y       <= y + 11'd1;
          bar_cnt <= '0;
          bar_idx <= '0;
        end else begin
          x <= x + 11'd1;
          if (bar_cnt == BAR_LAST) begin
            bar_cnt <= '0;
            if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
          end else begin
            bar_cnt <= bar_cnt + 11'd1;
          end
        end
      end
    end
  end

  assign in_box = ({1'b0, x} >= {1'b0, box_x}) && ({1'b0, x} < {1'b0, box_x} + BOX_LEN) &&
                  ({1'b0, y} >= {1'b0, box_y}) && ({1'b0, y} < {1'b0, box_y} + BOX_LEN);

  assign grid_on = ((x & CELL_MASK) == 11'd0) || ((y & CELL_MASK) == 11'd0) ||
                   (x == X_LAST) || (y == Y_LAST);

  // NOTE: data_c gets a default before any branch so no path can infer a latch.
  always_comb begin
    data_c = RGB_BLACK;
    if (!y_end) begin
      case (mode_r)
        MODE_BARS:    data_c = bar_colour(bar_idx);
        MODE_CHECKER: data_c = (x[CHECK_SHIFT] ^ y[CHECK_SHIFT]) ? RGB_WHITE : RGB_BLACK;
        MODE_GRID:    data_c = grid_on ? RGB_WHITE : RGB_BLACK;
        MODE_BOX:     data_c = in_box ? RGB_RED : RGB_BLUE;
        default:      data_c = RGB_BLACK;
      endcase
    end
  end

  assign DATA    = data_c;
  assign Pix_X   = x;
  assign Pix_Y   = y;
  assign Overrun = overrun;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench: full-size instance for pattern/box vectors, small instance
// (40x6) sharing the same inputs for end-of-frame and overrun behaviour.
module tb_vga_pattern_gen;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [1:0]  Mode = 2'd0;
  logic        Data_Req = 1'b0;
  logic        VGA_VS = 1'b1;

  logic [23:0] data, s_data;
  logic [10:0] pix_x, pix_y, s_pix_x, s_pix_y;
  logic        fs, s_fs, ovr, s_ovr;

  int errors = 0;
  int checks = 0;
  int nfs    = 0;

  always #5 Clk = ~Clk;

  vga_pattern_gen dut (
    .Clk(Clk), .Reset(Reset), .Mode(Mode), .Data_Req(Data_Req), .VGA_VS(VGA_VS),
    .DATA(data), .Pix_X(pix_x), .Pix_Y(pix_y), .Frame_Start(fs), .Overrun(ovr)
  );

  vga_pattern_gen #(
    .H_ACTIVE(40), .V_ACTIVE(6), .CHECK_SHIFT(2), .BOX_SIZE(4), .BOX_STEP(2)
  ) dut_s (
    .Clk(Clk), .Reset(Reset), .Mode(Mode), .Data_Req(Data_Req), .VGA_VS(VGA_VS),
    .DATA(s_data), .Pix_X(s_pix_x), .Pix_Y(s_pix_y), .Frame_Start(s_fs), .Overrun(s_ovr)
  );

  typedef struct packed {
    logic [1:0]  mode;
    logic [10:0] x;
    logic [10:0] y;
    logic [23:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read 1 unit later.
  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic adv(input int n);
    Data_Req = 1'b1;
    repeat (n) cyc();
    Data_Req = 1'b0;
  endtask

  task automatic new_frame(input logic [1:0] m);
    Mode   = m;
    VGA_VS = 1'b0;
    cyc();
    VGA_VS = 1'b1;
    cyc();
    nfs++;
  endtask

  // Triangle wave in steps of 2 between 0 and peak; period = peak frames.
  function automatic int tri_pos(input int n, input int peak);
    int p;
    p = n % peak;
    return (p <= peak / 2) ? 2 * p : 2 * (peak - p);
  endfunction

  initial begin
    int cur_mode;
    int cur_lin;
    int lin;
    int max_x;
    int max_y;

    // Bars
    vecs.push_back('{2'd0, 11'd0,   11'd0, 24'hFFFFFF});
    vecs.push_back('{2'd0, 11'd99,  11'd0, 24'hFFFFFF});
    vecs.push_back('{2'd0, 11'd100, 11'd0, 24'hFFFF00});
    vecs.push_back('{2'd0, 11'd250, 11'd0, 24'h00FFFF});
    vecs.push_back('{2'd0, 11'd799, 11'd0, 24'h000000});
    vecs.push_back('{2'd0, 11'd350, 11'd5, 24'h00FF00});
    vecs.push_back('{2'd0, 11'd450, 11'd5, 24'hFF00FF});
    vecs.push_back('{2'd0, 11'd550, 11'd5, 24'hFF0000});
    vecs.push_back('{2'd0, 11'd650, 11'd5, 24'h0000FF});
    vecs.push_back('{2'd0, 11'd799, 11'd5, 24'h000000});
    vecs.push_back('{2'd0, 11'd0,   11'd6, 24'hFFFFFF});
    // Checker: white where x[5]^y[5]
    vecs.push_back('{2'd1, 11'd31,  11'd0,  24'h000000});
    vecs.push_back('{2'd1, 11'd32,  11'd0,  24'hFFFFFF});
    vecs.push_back('{2'd1, 11'd64,  11'd0,  24'h000000});
    vecs.push_back('{2'd1, 11'd0,   11'd32, 24'hFFFFFF});
    vecs.push_back('{2'd1, 11'd32,  11'd32, 24'h000000});
    // Grid
    vecs.push_back('{2'd2, 11'd5,   11'd0, 24'hFFFFFF});
    vecs.push_back('{2'd2, 11'd0,   11'd7, 24'hFFFFFF});
    vecs.push_back('{2'd2, 11'd5,   11'd7, 24'h000000});
    vecs.push_back('{2'd2, 11'd33,  11'd7, 24'h000000});
    vecs.push_back('{2'd2, 11'd64,  11'd7, 24'hFFFFFF});
    vecs.push_back('{2'd2, 11'd798, 11'd7, 24'h000000});
    vecs.push_back('{2'd2, 11'd799, 11'd7, 24'hFFFFFF});

    // Reset state
    repeat (3) cyc();
    check("rst_data", 32'(data), 32'h00FFFFFF);
    check("rst_pix_x", 32'(pix_x), 32'd0);
    check("rst_pix_y", 32'(pix_y), 32'd0);
    check("rst_overrun", 32'(ovr), 32'd0);
    check("rst_frame_start", 32'(fs), 32'd0);
    Reset = 1'b0;
    cyc();

    // Table-driven pattern vectors, advancing the raster incrementally
    cur_mode = -1;
    cur_lin  = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      lin = int'(vecs[i].y) * 800 + int'(vecs[i].x);
      if (int'(vecs[i].mode) != cur_mode || lin < cur_lin) begin
        new_frame(vecs[i].mode);
        cur_mode = int'(vecs[i].mode);
        cur_lin  = 0;
      end
      adv(lin - cur_lin);
      cur_lin = lin;
      check($sformatf("vec%0d_data", i), 32'(data), 32'(vecs[i].exp));
      check($sformatf("vec%0d_pix_x", i), 32'(pix_x), 32'(vecs[i].x));
      check($sformatf("vec%0d_pix_y", i), 32'(pix_y), 32'(vecs[i].y));
    end

    // Reset mid-frame, then a mode change that must wait for the next frame
    Reset = 1'b1;
    cyc();
    check("midrst_pix_x", 32'(pix_x), 32'd0);
    check("midrst_pix_y", 32'(pix_y), 32'd0);
    Reset = 1'b0;
    nfs   = 0;
    Mode  = 2'd0;
    adv(99);
    check("mode_hold_99", 32'(data), 32'h00FFFFFF);
    Mode = 2'd3;
    adv(1);
    check("mode_hold_100", 32'(data), 32'h00FFFF00);
    check("mode_hold_x", 32'(pix_x), 32'd100);

    new_frame(2'd3);
    adv(800 + 2);
    check("box1_2_1", 32'(data), 32'h000000FF);
    adv(799);
    check("box1_1_2", 32'(data), 32'h000000FF);
    adv(1);
    check("box1_2_2", 32'(data), 32'h00FF0000);
    adv(63);
    check("box1_65_2", 32'(data), 32'h00FF0000);
    adv(1);
    check("box1_66_2", 32'(data), 32'h000000FF);

    new_frame(2'd3);
    adv(4 * 800 + 3);
    check("box2_3_4", 32'(data), 32'h000000FF);
    adv(1);
    check("box2_4_4", 32'(data), 32'h00FF0000);
    check("box2_pos_x", 32'(dut.box_x), 32'd4);
    check("box2_pos_y", 32'(dut.box_y), 32'd4);

    // Long bounce run with short frames
    max_x = 0;
    max_y = 0;
    while (nfs < 800) begin
      new_frame(2'd3);
      check($sformatf("bounce_x_f%0d", nfs), 32'(dut.box_x), 32'(tri_pos(nfs, 736)));
      check($sformatf("bounce_y_f%0d", nfs), 32'(dut.box_y), 32'(tri_pos(nfs, 416)));
      if (int'(dut.box_x) > max_x) max_x = int'(dut.box_x);
      if (int'(dut.box_y) > max_y) max_y = int'(dut.box_y);
    end
    check("bounce_peak_x", 32'(max_x), 32'd736);
    check("bounce_peak_y", 32'(max_y), 32'd416);

    // End of frame and overrun on the 40x6 instance (BAR_W = 5)
    new_frame(2'd0);
    adv(5);
    check("small_bar1", 32'(s_data), 32'h00FFFF00);
    adv(234);
    check("small_last_x", 32'(s_pix_x), 32'd39);
    check("small_last_y", 32'(s_pix_y), 32'd5);
    check("small_last_data", 32'(s_data), 32'h00000000);
    check("small_last_ovr", 32'(s_ovr), 32'd0);
    adv(1);
    check("small_end_y", 32'(s_pix_y), 32'd6);
    check("small_end_data", 32'(s_data), 32'h00000000);
    check("small_end_ovr", 32'(s_ovr), 32'd0);
    adv(3);
    check("ovr_set", 32'(s_ovr), 32'd1);
    check("ovr_x_hold", 32'(s_pix_x), 32'd0);
    check("ovr_y_hold", 32'(s_pix_y), 32'd6);
    repeat (5) cyc();
    check("ovr_sticky", 32'(s_ovr), 32'd1);
    check("ovr_data", 32'(s_data), 32'h00000000);

    // Frame start coincident with a request: request dropped, overrun cleared
    Data_Req = 1'b1;
    VGA_VS   = 1'b0;
    #1;
    check("fs_pulse", 32'(s_fs), 32'd1);
    cyc();
    Data_Req = 1'b0;
    VGA_VS   = 1'b1;
    #1;
    check("fs_pulse_end", 32'(s_fs), 32'd0);
    check("fs_req_x", 32'(s_pix_x), 32'd0);
    check("fs_req_y", 32'(s_pix_y), 32'd0);
    check("fs_ovr_clr", 32'(s_ovr), 32'd0);
    check("fs_data", 32'(s_data), 32'h00FFFFFF);
    check("fs_main_x", 32'(pix_x), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
